// File: rtl/s2c_call_arb.sv
// Round-robin arbiter sharing one SV-to-C call channel between NREQ requesters.
// Optional WAIT-state watchdog is enabled by defining S2C_TIMEOUT_EN.
module s2c_call_arb #(
  parameter int          NREQ        = 4,
  parameter int unsigned ID_BASE     = 0,
  parameter int          DATA_SIZE   = 16,
  parameter int          TIMEOUT_CYC = 1024,
  localparam int         IW          = $clog2(DATA_SIZE),
  localparam int         GW          = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    rq_valid,
  output logic [NREQ-1:0]    rq_ready,
  input  logic [NREQ*32-1:0] rq_fn,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [31:0]        dn_id,
  output logic [31:0]        dn_fn,
  input  logic               up_valid,
  input  logic [31:0]        up_ret,
  input  logic [31:0]        up_data,
  input  logic               up_last,
  output logic [NREQ-1:0]    rs_valid,
  output logic [31:0]        rs_ret,
  output logic [31:0]        rs_data,
  output logic [IW-1:0]      rs_idx,
  output logic               rs_last,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, g, g_sel, g_next;
  logic            found;
  logic [31:0]     fn_q, id_q;
  logic [IW-1:0]   cnt;
  logic            beat_end;
  logic [NREQ-1:0] g_onehot, sel_onehot;
  logic            abort;

`ifdef S2C_TIMEOUT_EN
  logic [31:0]     wd;
  logic            timeout_q;
  assign abort   = (state == S_WAIT) && !up_valid && (wd == 32'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Rotating priority search starting at rr_ptr.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    found = 1'b0;
    g_sel = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && rq_valid[idx]) begin
        found = 1'b1;
        g_sel = GW'(idx);
      end
    end
  end

  assign sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << g_sel;
  assign g_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << g;
  assign g_next     = (g == GW'(NREQ - 1)) ? '0 : g + 1'b1;
  assign beat_end   = up_last || (cnt == IW'(DATA_SIZE - 1));

  assign rq_ready = (state == S_IDLE && found) ? sel_onehot : '0;
  assign dn_valid = (state == S_ISSUE);
  assign dn_id    = id_q;
  assign dn_fn    = fn_q;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_ISSUE;
      S_ISSUE: if (dn_ready) state_nxt = S_WAIT;
      S_WAIT:  if ((up_valid && beat_end) || abort) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      fn_q     <= '0;
      id_q     <= '0;
      cnt      <= '0;
      rs_valid <= '0;
      rs_ret   <= '0;
      rs_data  <= '0;
      rs_idx   <= '0;
      rs_last  <= 1'b0;
`ifdef S2C_TIMEOUT_EN
      wd        <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      rs_valid <= '0;
      rs_last  <= 1'b0;
`ifdef S2C_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        S_IDLE: if (found) begin
          g    <= g_sel;
          fn_q <= rq_fn[32*g_sel +: 32];
          id_q <= ID_BASE + 32'(g_sel);
        end
        S_ISSUE: if (dn_ready) begin
          cnt <= '0;
`ifdef S2C_TIMEOUT_EN
          wd  <= '0;
`endif
        end
        S_WAIT: begin
          if (up_valid) begin
            rs_valid <= g_onehot;
            rs_data  <= up_data;
            rs_idx   <= cnt;
            rs_last  <= beat_end;
            if (cnt == '0) rs_ret <= up_ret;
            cnt <= cnt + 1'b1;
            if (beat_end) rr_ptr <= g_next;
`ifdef S2C_TIMEOUT_EN
            wd <= '0;
          end else if (abort) begin
            // Synthesised error beat so the requester is not left waiting forever.
            rs_valid  <= g_onehot;
            rs_ret    <= 32'hFFFF_FFFF;
            rs_data   <= '0;
            rs_idx    <= cnt;
            rs_last   <= 1'b1;
            timeout_q <= 1'b1;
            rr_ptr    <= g_next;
          end else begin
            wd <= wd + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s2c_call_arb.sv
// Self-checking bench for s2c_call_arb: transaction-level grant model plus a per-cycle response scoreboard.
module tb_s2c_call_arb;

  localparam int NREQ        = 4;
  localparam int DATA_SIZE   = 16;
  localparam int TIMEOUT_CYC = 8;
  localparam int IW          = $clog2(DATA_SIZE);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    rq_valid, rq_ready;
  logic [NREQ*32-1:0] rq_fn;
  logic               dn_valid, dn_ready;
  logic [31:0]        dn_id, dn_fn;
  logic               up_valid, up_last;
  logic [31:0]        up_ret, up_data;
  logic [NREQ-1:0]    rs_valid;
  logic [31:0]        rs_ret, rs_data;
  logic [IW-1:0]      rs_idx;
  logic               rs_last, busy, timeout;

  s2c_call_arb #(.NREQ(NREQ), .ID_BASE(0), .DATA_SIZE(DATA_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_fn(rq_fn),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_id(dn_id), .dn_fn(dn_fn),
    .up_valid(up_valid), .up_ret(up_ret), .up_data(up_data), .up_last(up_last),
    .rs_valid(rs_valid), .rs_ret(rs_ret), .rs_data(rs_data), .rs_idx(rs_idx), .rs_last(rs_last),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          g;
    int          idx;
    logic [31:0] ret;
    logic [31:0] data;
    bit          last;
    bit          to;
    int          due;
  } beat_t;

  beat_t       exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          m_rr = 0;
  logic [31:0] fn_tab[NREQ];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int i);
    logic [31:0] v;
    v = 32'd1 << i;
    return v;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fn();
    for (int i = 0; i < NREQ; i++) rq_fn[i*32 +: 32] = fn_tab[i];
  endtask

  // Scoreboard: every cycle either the next expected beat is due or no response activity is allowed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        beat_t e;
        e = exp_q.pop_front();
        check("rs_valid", 32'(rs_valid), onehot(e.g));
        check("rs_ret", rs_ret, e.ret);
        check("rs_data", rs_data, e.data);
        check("rs_last", 32'(rs_last), 32'(e.last));
        if (!e.to) check("rs_idx", 32'(rs_idx), 32'(e.idx));
        check("timeout_pulse", 32'(timeout), 32'(e.to));
      end else begin
        check("rs_valid_quiet", 32'(rs_valid), 32'd0);
        check("timeout_quiet", 32'(timeout), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          check("missed_beat_due", 32'(cyc), 32'(exp_q[0].due));
          void'(exp_q.pop_front());
        end
      end
      if (busy) check("rq_ready_while_busy", 32'(rq_ready), 32'd0);
    end
  end

  // One complete call: grant, issue (with optional stall), then response beats or a watchdog abort.
  task automatic do_call(input logic [NREQ-1:0] mask, input int exp_g, input int stall,
                         input int nbeats, input int last_at, input logic [31:0] ret,
                         input bit keep, input bit expect_to);
    int g;
    bit ended;
    g = model_grant(mask);
    if (exp_g >= 0) check("model_grant_pin", 32'(g), 32'(exp_g));
    rq_valid = mask;
    @(negedge clk);
    check("rq_ready_grant", 32'(rq_ready), onehot(g));
    check("busy_idle", 32'(busy), 32'd0);
    tick();
    if (!keep) rq_valid = '0;
    dn_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("dn_valid_stall", 32'(dn_valid), 32'd1);
      check("dn_id_stall", dn_id, 32'(g));
      check("dn_fn_stall", dn_fn, fn_tab[g]);
      tick();
    end
    dn_ready = 1'b1;
    @(negedge clk);
    check("dn_valid", 32'(dn_valid), 32'd1);
    check("dn_id", dn_id, 32'(g));
    check("dn_fn", dn_fn, fn_tab[g]);
    tick();
    dn_ready = 1'b0;
    ended = 1'b0;
    if (expect_to) begin
      exp_q.push_back('{g: g, idx: 0, ret: 32'hFFFF_FFFF, data: 32'd0, last: 1'b1, to: 1'b1,
                        due: cyc + TIMEOUT_CYC});
      repeat (TIMEOUT_CYC) tick();
      ended = 1'b1;
    end
    for (int b = 0; b < nbeats; b++) begin
      up_valid = 1'b1;
      up_data  = 32'h100 + 32'(b);
      up_ret   = (b == 0) ? ret : 32'hDEAD_0000 + 32'(b);
      up_last  = (b == last_at);
      if (!ended) begin
        exp_q.push_back('{g: g, idx: b, ret: ret, data: 32'h100 + 32'(b),
                          last: (b == last_at) || (b == DATA_SIZE - 1), to: 1'b0, due: cyc + 1});
        ended = (b == last_at) || (b == DATA_SIZE - 1);
      end
      tick();
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
    if (ended) m_rr = (g + 1) % NREQ;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    rq_valid = '0;
    dn_ready = 1'b0;
    up_valid = 1'b0;
    up_last  = 1'b0;
    up_ret   = '0;
    up_data  = '0;
    repeat (3) tick();
    m_rr = 0;
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: actual expired, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) fn_tab[i] = 32'hA0 + 32'(i);
    load_fn();

    // Reset: outputs quiet while rst_n is low.
    rst_n    = 1'b0;
    rq_valid = '0;
    dn_ready = 1'b0;
    up_valid = 1'b0;
    up_last  = 1'b0;
    up_ret   = '0;
    up_data  = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rq_ready", 32'(rq_ready), 32'd0);
    check("rst_dn_valid", 32'(dn_valid), 32'd0);
    check("rst_rs_valid", 32'(rs_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin with all requesters held: order 0,1,2,3,0.
    do_call(4'b1111, 0, 0, 1, 0, 32'h11, 1'b1, 1'b0);
    do_call(4'b1111, 1, 0, 1, 0, 32'h12, 1'b1, 1'b0);
    do_call(4'b1111, 2, 0, 1, 0, 32'h13, 1'b1, 1'b0);
    do_call(4'b1111, 3, 0, 1, 0, 32'h14, 1'b1, 1'b0);
    do_call(4'b1111, 0, 0, 1, 0, 32'h15, 1'b0, 1'b0);

    // Single call from requester 2: fn=5, ret=7, 16 beats ending on last at beat 15.
    fn_tab[2] = 32'd5;
    load_fn();
    do_call(4'b0100, 2, 0, 16, 15, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("single_back_idle", 32'(busy), 32'd0);
    tick();

    // Backpressure on the downstream channel, then early last on beat 3.
    do_call(4'b1001, 3, 5, 6, 3, 32'h44, 1'b0, 1'b0);
    @(negedge clk);
    check("early_last_idle", 32'(busy), 32'd0);
    tick();

    // Overrun: 20 beats without last; forced end at 15, then a stray beat while idle.
    do_call(4'b0010, 1, 0, 20, -1, 32'h55, 1'b0, 1'b0);
    tick();
    up_valid = 1'b1;
    up_data  = 32'hBAD;
    tick();
    up_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("overrun_idle", 32'(busy), 32'd0);
    tick();

`ifdef S2C_TIMEOUT_EN
    // Watchdog: no response, error beat, then the next pending requester wins.
    do_call(4'b0101, 2, 0, 0, -1, 32'h0, 1'b1, 1'b1);
    do_call(4'b0101, 0, 0, 1, 0, 32'h66, 1'b0, 1'b0);
    tick();
`else
    // No watchdog: the call hangs until reset abandons it without any response beat.
    do_call(4'b0101, 2, 0, 0, -1, 32'h0, 1'b0, 1'b0);
    repeat (40) tick();
    @(negedge clk);
    check("hang_busy", 32'(busy), 32'd1);
    tick();
`endif
    apply_reset();
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_dn_valid", 32'(dn_valid), 32'd0);
    tick();
    do_call(4'b1110, 1, 0, 2, 1, 32'h77, 1'b0, 1'b0);
    repeat (3) tick();
    if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
